// File: rtl/wb_regfile_stage_if.sv
// Bus bundle for wb_regfile_stage: EX_WB input register, operand read port,
// issue/hazard signals and commit/retire outputs.
interface wb_regfile_stage_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   localparam int AW = $clog2(NREGS);

   typedef struct packed {
      logic [XLEN-1:0] alu_result;
      logic            alu_result_ready;
      logic [AW-1:0]   reg_wr_addr;
      logic            reg_wr_en;
   } ex_wb_t;

   ex_wb_t          ex_wb_reg;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic            rd_en;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            issue_valid;
   logic [AW-1:0]   issue_rd;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            commit_valid;
   logic [AW-1:0]   commit_addr;
   logic [XLEN-1:0] commit_data;
   logic [31:0]     retired_count;

   modport master (
      output ex_wb_reg, rs1_addr, rs2_addr, rd_en, issue_valid, issue_rd,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy,
             commit_valid, commit_addr, commit_data, retired_count
   );

   modport slave (
      input  ex_wb_reg, rs1_addr, rs2_addr, rd_en, issue_valid, issue_rd,
      output rs1_data, rs2_data, rs1_busy, rs2_busy,
             commit_valid, commit_addr, commit_data, retired_count
   );
endinterface

// File: rtl/wb_regfile_stage.sv
// Writeback stage + register file with write bypass and RAW scoreboard.
// Optional retire counter enabled by defining WB_RETIRE_COUNTER_EN.
module wb_regfile_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input logic               clk,
   input logic               reset,
   wb_regfile_stage_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic            we;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic            commit_valid_q, commit_valid_d;
   logic [AW-1:0]   commit_addr_q, commit_addr_d;
   logic [XLEN-1:0] commit_data_q, commit_data_d;

   assign wr_addr = bus.ex_wb_reg.reg_wr_addr;
   assign wr_data = bus.ex_wb_reg.alu_result;

   always_comb begin
      we = bus.ex_wb_reg.alu_result_ready & bus.ex_wb_reg.reg_wr_en & (wr_addr != '0);

      regs_d = regs_q;
      if (we)
         regs_d[wr_addr] = wr_data;
      regs_d[0] = '0;

      // Clear first, then set, so a same-address issue keeps the bit busy
      busy_d = busy_q;
      if (we)
         busy_d[wr_addr] = 1'b0;
      if (bus.issue_valid && (bus.issue_rd != '0))
         busy_d[bus.issue_rd] = 1'b1;
      busy_d[0] = 1'b0;

      commit_valid_d = we;
      commit_addr_d  = commit_addr_q;
      commit_data_d  = commit_data_q;
      if (we) begin
         commit_addr_d = wr_addr;
         commit_data_d = wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q         <= '{default: '0};
         busy_q         <= '0;
         commit_valid_q <= 1'b0;
         commit_addr_q  <= '0;
         commit_data_q  <= '0;
      end else begin
         regs_q         <= regs_d;
         busy_q         <= busy_d;
         commit_valid_q <= commit_valid_d;
         commit_addr_q  <= commit_addr_d;
         commit_data_q  <= commit_data_d;
      end
   end

   assign bus.commit_valid = commit_valid_q;
   assign bus.commit_addr  = commit_addr_q;
   assign bus.commit_data  = commit_data_q;

   // Two identical read ports: port 0 feeds operand A, port 1 operand B
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [AW-1:0]   addr;
         logic [XLEN-1:0] data_q, data_d;
         logic            hit;

         assign addr = (gi == 0) ? bus.rs1_addr : bus.rs2_addr;
         assign hit  = we && (wr_addr == addr);

         always_comb begin
            data_d = data_q;
            if (bus.rd_en) begin
               if (addr == '0)
                  data_d = '0;
               else if (hit)
                  data_d = wr_data;
               else
                  data_d = regs_q[addr];
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               data_q <= '0;
            else
               data_q <= data_d;
         end

         if (gi == 0) begin : g_a
            assign bus.rs1_data = data_q;
            assign bus.rs1_busy = busy_q[addr] & ~hit;
         end else begin : g_b
            assign bus.rs2_data = data_q;
            assign bus.rs2_busy = busy_q[addr] & ~hit;
         end
      end
   endgenerate

`ifdef WB_RETIRE_COUNTER_EN
   logic [31:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q;
      if (bus.ex_wb_reg.alu_result_ready)
         retired_d = retired_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         retired_q <= '0;
      else
         retired_q <= retired_d;
   end

   assign bus.retired_count = retired_q;
`else
   assign bus.retired_count = '0;
`endif
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed self-checking bench for wb_regfile_stage (defaults XLEN=32, NREGS=32).
module tb_wb_regfile_stage;
   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;

   wb_regfile_stage_if bus ();

   wb_regfile_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.ex_wb_reg.alu_result       = '0;
      bus.ex_wb_reg.alu_result_ready = 1'b0;
      bus.ex_wb_reg.reg_wr_addr      = '0;
      bus.ex_wb_reg.reg_wr_en        = 1'b0;
      bus.rd_en       = 1'b0;
      bus.rs1_addr    = '0;
      bus.rs2_addr    = '0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
   endtask

   task automatic wb(input logic rdy, input logic en, input logic [4:0] a, input logic [31:0] d);
      bus.ex_wb_reg.alu_result       = d;
      bus.ex_wb_reg.alu_result_ready = rdy;
      bus.ex_wb_reg.reg_wr_addr      = a;
      bus.ex_wb_reg.reg_wr_en        = en;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      bus.rd_en    = 1'b1;
      bus.rs1_addr = a1;
      bus.rs2_addr = a2;
   endtask

   task automatic issue(input logic [4:0] r);
      bus.issue_valid = 1'b1;
      bus.issue_rd    = r;
   endtask

   // Inputs change and outputs are sampled in the low phase
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state and first read
      rd(5'd5, 5'd0);
      #1;
      chk("reset_rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
      chk("reset_rs2_busy", {31'd0, bus.rs2_busy}, 32'd0);
      step();
      chk("reset_rs1_data", bus.rs1_data, 32'd0);
      chk("reset_rs2_data", bus.rs2_data, 32'd0);
      chk("reset_commit_valid", {31'd0, bus.commit_valid}, 32'd0);
      chk("reset_retired", bus.retired_count, 32'd0);

      // Write x5, read it back
      idle();
      wb(1'b1, 1'b1, 5'd5, 32'h12345678);
      step();
      chk("w5_commit_valid", {31'd0, bus.commit_valid}, 32'd1);
      chk("w5_commit_addr", {27'd0, bus.commit_addr}, 32'd5);
      chk("w5_commit_data", bus.commit_data, 32'h12345678);
      idle();
      rd(5'd5, 5'd0);
      step();
      chk("r5_rs1_data", bus.rs1_data, 32'h12345678);
      chk("r5_commit_valid", {31'd0, bus.commit_valid}, 32'd0);
      chk("r5_commit_addr_hold", {27'd0, bus.commit_addr}, 32'd5);

      // Same-cycle bypass on both ports
      idle();
      wb(1'b1, 1'b1, 5'd7, 32'hCAFEF00D);
      rd(5'd7, 5'd7);
      step();
      chk("byp_rs1_data", bus.rs1_data, 32'hCAFEF00D);
      chk("byp_rs2_data", bus.rs2_data, 32'hCAFEF00D);

      // x0 write discarded, commit holds
      idle();
      wb(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
      bus.rs1_addr = 5'd5;
      step();
      chk("x0w_commit_valid", {31'd0, bus.commit_valid}, 32'd0);
      chk("x0w_commit_addr_hold", {27'd0, bus.commit_addr}, 32'd7);
      chk("x0w_commit_data_hold", bus.commit_data, 32'hCAFEF00D);
      chk("rden0_rs1_hold", bus.rs1_data, 32'hCAFEF00D);
      idle();
      rd(5'd0, 5'd0);
      step();
      chk("x0r_rs1_data", bus.rs1_data, 32'd0);
      chk("x0r_rs2_data", bus.rs2_data, 32'd0);

      // ready=0 with wr_en: no write, no bypass
      idle();
      wb(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
      rd(5'd5, 5'd7);
      step();
      chk("nrdy_rs1_data", bus.rs1_data, 32'h12345678);
      chk("nrdy_rs2_data", bus.rs2_data, 32'hCAFEF00D);
      chk("nrdy_commit_valid", {31'd0, bus.commit_valid}, 32'd0);

      // Scoreboard set / clear
      idle();
      issue(5'd3);
      step();
      idle();
      bus.rs1_addr = 5'd3;
      #1;
      chk("sb_set_busy", {31'd0, bus.rs1_busy}, 32'd1);
      wb(1'b1, 1'b1, 5'd3, 32'h00000033);
      #1;
      chk("sb_bypass_busy", {31'd0, bus.rs1_busy}, 32'd0);
      step();
      idle();
      bus.rs1_addr = 5'd3;
      #1;
      chk("sb_cleared_busy", {31'd0, bus.rs1_busy}, 32'd0);

      // Same address set+clear: set wins
      issue(5'd3);
      wb(1'b1, 1'b1, 5'd3, 32'h00000034);
      step();
      idle();
      bus.rs1_addr = 5'd3;
      #1;
      chk("sb_setwins_busy", {31'd0, bus.rs1_busy}, 32'd1);

      // Different addresses: clear x3, set x4
      issue(5'd4);
      wb(1'b1, 1'b1, 5'd3, 32'h00000035);
      step();
      idle();
      bus.rs1_addr = 5'd3;
      bus.rs2_addr = 5'd4;
      #1;
      chk("sb_diff_rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
      chk("sb_diff_rs2_busy", {31'd0, bus.rs2_busy}, 32'd1);

      // Retire without write does not clear
      wb(1'b1, 1'b0, 5'd4, 32'h00000044);
      step();
      idle();
      bus.rs2_addr = 5'd4;
      #1;
      chk("sb_noen_rs2_busy", {31'd0, bus.rs2_busy}, 32'd1);
      issue(5'd0);
      step();
      idle();
      #1;
      chk("sb_x0_busy", {31'd0, bus.rs1_busy}, 32'd0);

      // Mid-stream async reset
      wb(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5);
      issue(5'd9);
      step();
      idle();
      wb(1'b1, 1'b1, 5'd10, 32'h00000001);
      rd(5'd9, 5'd0);
      step();
      chk("pre_rst_rs1_data", bus.rs1_data, 32'hA5A5A5A5);
      chk("pre_rst_commit_valid", {31'd0, bus.commit_valid}, 32'd1);
      idle();
      bus.rs1_addr = 5'd9;
      #1;
      chk("pre_rst_rs1_busy", {31'd0, bus.rs1_busy}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_rs1_data", bus.rs1_data, 32'd0);
      chk("rst_rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
      chk("rst_commit_valid", {31'd0, bus.commit_valid}, 32'd0);
      chk("rst_commit_addr", {27'd0, bus.commit_addr}, 32'd0);
      chk("rst_commit_data", bus.commit_data, 32'd0);
      chk("rst_retired", bus.retired_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rd(5'd9, 5'd10);
      step();
      chk("post_rst_x9", bus.rs1_data, 32'd0);
      chk("post_rst_x10", bus.rs2_data, 32'd0);

      // Ten retire cycles, mixing wr_en=0 and x0 targets
      idle();
      for (int i = 0; i < 10; i++) begin
         wb(1'b1, (i % 2) == 0, (i % 3) == 0 ? 5'd0 : 5'(i + 11), 32'(i));
         step();
      end
      idle();
      step();
`ifdef WB_RETIRE_COUNTER_EN
      chk("retired_10", bus.retired_count, 32'd10);
      force dut.retired_q = 32'hFFFFFFFF;
      step();
      release dut.retired_q;
      #1;
      chk("retired_preload", bus.retired_count, 32'hFFFFFFFF);
      wb(1'b1, 1'b0, 5'd0, 32'd0);
      step();
      idle();
      chk("retired_wrap", bus.retired_count, 32'd0);
`else
      chk("retired_off", bus.retired_count, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
